csa_mult_seq: RTL and testbench
===============================

CSA_MULT_SEQ -- requirements
Module: csa_mult_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 24 bits and the result vectors at 48 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  24  multiplicand, unsigned; sampled on the start-accept edge.
REQ-006 b  input  24  multiplier, unsigned; sampled on the start-accept edge.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 valid  output  1  one-cycle pulse; sum_vec/carry_vec hold a finished result.
REQ-009 sum_vec  output  48  carry-save sum vector; feeds operand a of the 48-bit final adder.
REQ-010 carry_vec  output  48  carry-save carry vector; feeds operand b of the 48-bit final adder.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 In IDLE, start=1 SHALL do all of the following on that edge: latch a into a_reg (48 bits, zero-extended) and b into b_reg; clear sum_vec, carry_vec and the iteration counter; go to RUN.
REQ-013 Each RUN cycle SHALL perform these steps:
  - form pp = b_reg[0] ? a_reg : 0;
  - update sum_vec <= sum_vec ^ carry_vec ^ pp;
  - update carry_vec <= (majority(sum_vec, carry_vec, pp) << 1), truncated to 48 bits;
  - shift a_reg left 1 and b_reg right 1;
  - increment the counter.
REQ-014 RUN SHALL go to DONE on the edge that processes iteration 23 (the counter runs 0..23).
REQ-015 DONE SHALL drive valid=1 for exactly one cycle, then go to IDLE.
REQ-016 For any a and b, sum_vec + carry_vec SHALL equal a*b exactly while valid=1; bit 47 of the majority term is never set, so a 49-bit sum of the two vectors always has bit 48 equal to 0.
REQ-017 sum_vec and carry_vec SHALL hold their DONE values through IDLE until the next start is accepted.
REQ-018 Latency SHALL be fixed: valid is high in the cycle following the 24th rising edge after the start-accept edge.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing.
REQ-020 start held high continuously SHALL begin a new multiply on the first edge in IDLE after DONE, i.e. back-to-back with one IDLE cycle.
REQ-021 Inputs a and b SHALL be don't-care outside the start-accept edge.

Reset
REQ-022 rst_n=0 SHALL immediately force the following, independent of clk:
  - state=IDLE;
  - busy=0 and valid=0;
  - sum_vec, carry_vec, a_reg, b_reg and the counter to 0.
REQ-023 Reset asserted during RUN or DONE SHALL abort the operation, with no valid pulse for it.
REQ-024 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-025 Macro CSA_MULT_EARLY_TERM_EN SHALL control early termination.
REQ-026 When CSA_MULT_EARLY_TERM_EN is defined, RUN SHALL also go to DONE on any edge where the shifted b_reg value becomes 0; latency is then (index of the highest set bit of b) + 1 edges, with a minimum of 1 edge for b=0 or b=1.
REQ-027 When CSA_MULT_EARLY_TERM_EN is not defined, latency SHALL always be 24 edges, per REQ-018.
REQ-028 REQ-016 SHALL hold in both builds.

Verification
REQ-029 Scenario: a=0xFFFFFF, b=0xFFFFFF -> sum_vec+carry_vec=0xFFFFFE000001, bit 48 of the sum=0, valid 24 edges after accept.
REQ-030 Scenario: a=0x000003, b=0x000005 -> sum_vec+carry_vec=0x00000000000F.
  - early-term build: valid after 3 edges;
  - default build: valid after 24 edges.
REQ-031 Scenario: a=0x123456, b=0 -> sum_vec=carry_vec=0, valid after 1 edge (early-term build) or 24 edges (default build).
REQ-032 Scenario: start re-pulsed at RUN cycle 5 with a=1, b=1 -> ignored; result is the first operand pair; exactly one valid pulse.
REQ-033 Scenario: rst_n low at RUN cycle 10 -> busy=0, valid=0 and vectors=0 immediately, no valid pulse; a new start then gives a correct result.
REQ-034 Scenario: start held high for 3 operations with random operands -> three valid pulses, each separated by one IDLE cycle, all three products correct.

Source files
------------

// File: rtl/csa_mult_seq_if.sv
// ---------------------------------------------------------------------------
// csa_mult_seq_if
//
// Purpose: bundles the request and result signals of the sequential
// carry-save multiplier so that the requester and the multiplier share
// one port.
//
// Signals:
//   start     requester -> multiplier  begin a multiply (taken only when idle)
//   a         requester -> multiplier  24-bit unsigned multiplicand
//   b         requester -> multiplier  24-bit unsigned multiplier
//   busy      multiplier -> requester  high whenever the multiplier is not idle
//   valid     multiplier -> requester  one-cycle pulse, result vectors final
//   sum_vec   multiplier -> requester  48-bit carry-save sum vector
//   carry_vec multiplier -> requester  48-bit carry-save carry vector
//
// Modports:
//   master  the requester side (drives start/a/b)
//   slave   the multiplier side (drives busy/valid/sum_vec/carry_vec)
// ---------------------------------------------------------------------------
interface csa_mult_seq_if;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        valid;
  logic [47:0] sum_vec;
  logic [47:0] carry_vec;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  valid,
    input  sum_vec,
    input  carry_vec
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output valid,
    output sum_vec,
    output carry_vec
  );
endinterface

// File: rtl/csa_mult_seq.sv
// ---------------------------------------------------------------------------
// csa_mult_seq
//
// Purpose: 24x24 unsigned shift-and-add multiplier that keeps its running
// total in carry-save form. One partial product is folded into the
// (sum_vec, carry_vec) pair per clock with a row of full adders, so no
// carry chain exists inside the loop. The requester finishes the multiply
// with a 48-bit adder: a*b == sum_vec + carry_vec while valid is high.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset
//   bus    csa_mult_seq_if.slave
//            start/a/b in, busy/valid/sum_vec/carry_vec out
//
// Configuration:
//   CSA_MULT_EARLY_TERM_EN  when defined, the loop stops as soon as the
//                           remaining multiplier bits are all zero, so the
//                           latency becomes (index of highest set bit of b)+1
//                           edges, minimum 1. When undefined, every multiply
//                           takes exactly 24 edges.
// ---------------------------------------------------------------------------
module csa_mult_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_mult_seq_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'd23;

  state_t      state_q,  state_d;
  logic [47:0] a_reg_q,  a_reg_d;
  logic [23:0] b_reg_q,  b_reg_d;
  logic [47:0] sum_q,    sum_d;
  logic [47:0] carry_q,  carry_d;
  logic [4:0]  cnt_q,    cnt_d;

  logic [47:0] pp;
  logic [47:0] maj;

  // State register. Reset clears everything so an aborted multiply leaves
  // no trace on the result vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_reg_q <= '0;
      b_reg_q <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Carry-save accumulation step: a row of full adders adds the current
  // partial product to the (sum, carry) pair. The majority term moves up one
  // weight; its top bit can never be set because the running total stays
  // below 2^48, so dropping it in the shift loses nothing.
  always_comb begin
    pp  = b_reg_q[0] ? a_reg_q : 48'd0;
    maj = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
  end

  // Next-state and datapath control. Every register holds by default, which
  // keeps the finished result visible through IDLE until the next start.
  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_reg_d = {24'd0, bus.a};
          b_reg_d = bus.b;
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        sum_d   = sum_q ^ carry_q ^ pp;
        carry_d = maj << 1;
        a_reg_d = a_reg_q << 1;
        b_reg_d = b_reg_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
`ifdef CSA_MULT_EARLY_TERM_EN
        // Once no multiplier bits remain, further iterations would only add
        // zero partial products, so finish now.
        if (b_reg_d == 24'd0) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.valid     = (state_q == DONE);
  assign bus.sum_vec   = sum_q;
  assign bus.carry_vec = carry_q;

endmodule

// File: tb/tb_csa_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_csa_mult_seq
//
// Purpose: self-checking bench for csa_mult_seq. Expected products and the
// edge on which valid must appear are queued when a start is accepted and
// compared when valid is observed. Honors CSA_MULT_EARLY_TERM_EN for the
// expected latency.
// ---------------------------------------------------------------------------
module tb_csa_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  csa_mult_seq_if mif ();

  csa_mult_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] prod;
    int unsigned dueEdge;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monE;
  logic [48:0] monTot;
  int unsigned edgeCnt   = 0;
  int unsigned vecCount  = 0;
  int unsigned missCount = 0;
  logic [47:0] lastProd  = '0;

  // Rising-edge counter used to time-stamp accepts and valid pulses
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected number of RUN edges for a given multiplier
  function automatic int unsigned expLat(input logic [23:0] bv);
`ifdef CSA_MULT_EARLY_TERM_EN
    int unsigned l = 1;
    for (int i = 0; i < 24; i++) begin
      if (bv[i]) l = i + 1;
    end
    return l;
`else
    return 24;
`endif
  endfunction

  // Called #1 after the accept edge: queues product and the valid edge
  task automatic pushExp(input logic [23:0] av, input logic [23:0] bv);
    exp_t e;
    e.prod    = {24'd0, av} * {24'd0, bv};
    e.dueEdge = edgeCnt + expLat(bv);
    sbQ.push_back(e);
    lastProd  = e.prod;
  endtask

  // Drives one start request (caller is away from a clock edge and the DUT
  // is idle), so the next rising edge is the accept edge.
  task automatic applyStimulus(input logic [23:0] av, input logic [23:0] bv);
    mif.start = 1'b1;
    mif.a     = av;
    mif.b     = bv;
    @(posedge clk);
    #1;
    pushExp(av, bv);
    mif.start = 1'b0;
    mif.a     = $urandom;
    mif.b     = $urandom;
  endtask

  // Waits, with a bound, until every queued result has been seen
  task automatic waitIdle(input string tag);
    int n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput({tag, "_timeout"}, 64'(sbQ.size()), 64'd0);
      sbQ.delete();
    end
    #1;
  endtask

  // Results must stay put in IDLE until the next start
  task automatic checkHold(input string tag);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_hold"}, 64'({1'b0, mif.sum_vec} + {1'b0, mif.carry_vec}),
                64'(lastProd));
    checkOutput({tag, "_idle_busy"}, 64'(mif.busy), 64'd0);
  endtask

  // Scoreboard side: every valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && mif.valid === 1'b1) begin
      monTot = {1'b0, mif.sum_vec} + {1'b0, mif.carry_vec};
      if (sbQ.size() == 0) begin
        checkOutput("spurious_valid", 64'd1, 64'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("product", 64'(monTot), 64'({1'b0, monE.prod}));
        checkOutput("latency", 64'(edgeCnt), 64'(monE.dueEdge));
      end
    end
  end

  // Back-to-back multiplies with start held high
  task automatic heldRun();
    logic [23:0] av, bv;
    int unsigned lat;
    av = 24'($urandom);
    bv = 24'($urandom);
    mif.start = 1'b1;
    mif.a     = av;
    mif.b     = bv;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      lat = expLat(bv);
      pushExp(av, bv);
      if (k == 2) begin
        mif.start = 1'b0;
      end else begin
        av    = 24'($urandom);
        bv    = 24'($urandom);
        mif.a = av;
        mif.b = bv;
        repeat (lat + 2) @(posedge clk);
        #1;
      end
    end
    waitIdle("held");
  endtask

  initial begin
    logic [23:0] ra, rb;
    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;

    // Reset state
    #12;
    checkOutput("rst_busy",  64'(mif.busy),      64'd0);
    checkOutput("rst_valid", 64'(mif.valid),     64'd0);
    checkOutput("rst_sum",   64'(mif.sum_vec),   64'd0);
    checkOutput("rst_carry", 64'(mif.carry_vec), 64'd0);

    // Largest operands, accepted on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(24'hFFFFFF, 24'hFFFFFF);
    checkOutput("max_run_busy", 64'(mif.busy), 64'd1);
    waitIdle("max");
    checkOutput("max_const", 64'(lastProd), 64'h0000_FFFF_FE00_0001);
    checkHold("max");

    // Small operands
    applyStimulus(24'h000003, 24'h000005);
    waitIdle("small");
    checkHold("small");

    // Zero and one multipliers
    applyStimulus(24'h123456, 24'h000000);
    waitIdle("bzero");
    checkHold("bzero");
    checkOutput("bzero_sum",   64'(mif.sum_vec),   64'd0);
    checkOutput("bzero_carry", 64'(mif.carry_vec), 64'd0);
    applyStimulus(24'hABCDEF, 24'h000001);
    waitIdle("bone");

    // Random operands
    for (int i = 0; i < 6; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      applyStimulus(ra, rb);
      waitIdle("rand");
    end

    // start re-pulsed mid-run must be ignored
    applyStimulus(24'h654321, 24'hABCDEF);
    repeat (5) @(posedge clk);
    #1;
    mif.start = 1'b1;
    mif.a     = 24'h000001;
    mif.b     = 24'h000001;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    waitIdle("repulse");
    repeat (30) @(posedge clk);
    #1;

    // Reset in the middle of RUN aborts without a valid pulse
    applyStimulus(24'h5A5A5A, 24'hFFFFFF);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",  64'(mif.busy),      64'd0);
    checkOutput("abort_valid", 64'(mif.valid),     64'd0);
    checkOutput("abort_sum",   64'(mif.sum_vec),   64'd0);
    checkOutput("abort_carry", 64'(mif.carry_vec), 64'd0);
    sbQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(24'hC0FFEE, 24'h00BEEF);
    waitIdle("after_abort");

    // Three back-to-back multiplies with start held
    heldRun();
    repeat (4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  // Global watchdog so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
